alu_instr_sequencer: RTL and testbench



---
 rtl/alu_instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_instr_sequencer
// Purpose  : Fetch/decode/execute micro-step controller for the single-bus
//            datapath; drives bus-source select and register load strobes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_instr_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [4:0]  bus_select,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        mem_read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } stateT;

  localparam logic [4:0] C_SEL_HI   = 5'd16;
  localparam logic [4:0] C_SEL_ZHI  = 5'd18;
  localparam logic [4:0] C_SEL_ZLO  = 5'd19;
  localparam logic [4:0] C_SEL_PC   = 5'd20;
  localparam logic [4:0] C_SEL_MDR  = 5'd21;
  localparam logic [4:0] C_SEL_CSX  = 5'd23;

  stateT       r_state;
  logic        r_t1First;
  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_legal;
  logic        w_mulDiv;
  logic        w_isAddi;
  logic        w_unusedIr;

  assign w_op       = ir[31:27];
  assign w_ra       = ir[26:23];
  assign w_rb       = ir[22:19];
  assign w_rc       = ir[18:15];
  assign w_unusedIr = ^ir[14:0];
  assign w_mulDiv   = (w_op == 5'b01111) || (w_op == 5'b10000);
  assign w_isAddi   = (w_op == 5'b01100);
  assign w_legal    = (w_op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                    5'b01100, 5'b01111, 5'b10000});

  // r_t1First marks the entry cycle of T1 so PC is loaded exactly once per fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_t1First <= 1'b1;
    end else begin
      r_t1First <= (r_state != S_T1);
      case (r_state)
        S_IDLE: if (start) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (mem_ready) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3:   begin
          if (w_legal) r_state <= S_T4;
          else         r_state <= start ? S_T0 : S_IDLE;
        end
        S_T4:   r_state <= S_T5;
        S_T5:   begin
          if (w_mulDiv) r_state <= S_T6;
          else          r_state <= start ? S_T0 : S_IDLE;
        end
        S_T6:   r_state <= start ? S_T0 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_select = 5'd0;
    reg_in     = 16'd0;
    pc_in      = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    mem_read   = 1'b0;
    alu_op     = 5'd0;
    done       = 1'b0;
    illegal    = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_T0: begin
        bus_select = C_SEL_PC;
        mar_in     = 1'b1;
        inc_pc     = 1'b1;
        z_in       = 1'b1;
      end
      S_T1: begin
        bus_select = C_SEL_ZLO;
        mem_read   = 1'b1;
        pc_in      = r_t1First;
        mdr_in     = mem_ready;
      end
      S_T2: begin
        bus_select = C_SEL_MDR;
        ir_in      = 1'b1;
      end
      S_T3: begin
        if (!w_legal) begin
          illegal = 1'b1;
          done    = 1'b1;
        end else begin
          bus_select = {1'b0, w_rb};
          y_in       = 1'b1;
        end
      end
      S_T4: begin
        alu_op     = w_op;
        z_in       = 1'b1;
        bus_select = w_isAddi ? C_SEL_CSX : {1'b0, w_rc};
      end
      S_T5: begin
        bus_select = C_SEL_ZLO;
        if (w_mulDiv) begin
          lo_in = 1'b1;
        end else begin
          reg_in = 16'd1 << w_ra;
          done   = 1'b1;
        end
      end
      S_T6: begin
        bus_select = C_SEL_ZHI;
        hi_in      = 1'b1;
        done       = 1'b1;
      end
      default: begin
        bus_select = 5'd0;
      end
    endcase
    if (C_SEL_HI == 5'd0) bus_select = 5'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_instr_sequencer
// Purpose  : Directed scoreboard bench for the instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic [4:0]  bus_select;
  logic [15:0] reg_in;
  logic        pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic        mem_read;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  always #5 clock = ~clock;

  alu_instr_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .bus_select (bus_select),
    .reg_in     (reg_in),
    .pc_in      (pc_in),
    .inc_pc     (inc_pc),
    .mar_in     (mar_in),
    .mdr_in     (mdr_in),
    .ir_in      (ir_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .mem_read   (mem_read),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  // Strobe vector layout: {pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, mem_read}
  localparam logic [9:0] S_PC  = 10'b1000000000;
  localparam logic [9:0] S_INC = 10'b0100000000;
  localparam logic [9:0] S_MAR = 10'b0010000000;
  localparam logic [9:0] S_MDR = 10'b0001000000;
  localparam logic [9:0] S_IR  = 10'b0000100000;
  localparam logic [9:0] S_Y   = 10'b0000010000;
  localparam logic [9:0] S_Z   = 10'b0000001000;
  localparam logic [9:0] S_HI  = 10'b0000000100;
  localparam logic [9:0] S_LO  = 10'b0000000010;
  localparam logic [9:0] S_RD  = 10'b0000000001;

  typedef struct {
    logic [38:0] vec;
    string       tag;
  } expT;

  expT sb[$];
  int  tests    = 0;
  int  failures = 0;
  int  budget   = 1000000;

  wire [38:0] obs = {bus_select, reg_in,
                     pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, mem_read,
                     alu_op, busy, done, illegal};

  function automatic logic [38:0] mk(input logic [4:0] bs, input logic [15:0] rg,
                                     input logic [9:0] st, input logic [4:0] ao,
                                     input logic bz, input logic dn, input logic il);
    return {bs, rg, st, ao, bz, dn, il};
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic check();
    expT e;
    tests++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard-empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic push(input string tag, input logic [38:0] v);
    expT e;
    e.vec = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock: drive inputs just after the edge, record expectation, sample.
  task automatic cyc(input string tag, input logic [38:0] v, input logic st,
                     input logic mr, input logic [31:0] irv);
    if (budget == 0) return;
    budget--;
    @(posedge clock);
    #1;
    start     = st;
    mem_ready = mr;
    ir        = irv;
    push(tag, v);
    #1;
    check();
  endtask

  task automatic idle(input logic st, input logic [31:0] irv);
    cyc("idle", mk(5'd0, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b0), st, 1'b1, irv);
  endtask

  // Expected micro-step trace of one instruction starting in T0.
  task automatic runInstr(input logic [31:0] irv, input int nWait, input logic endStart);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       legal, mulDiv;
    logic       mr;
    op     = irv[31:27];
    ra     = irv[26:23];
    rb     = irv[22:19];
    rc     = irv[18:15];
    legal  = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6) ||
             (op == 5'd12) || (op == 5'd15) || (op == 5'd16);
    mulDiv = (op == 5'd15) || (op == 5'd16);
    cyc("T0", mk(5'd20, 16'd0, S_INC | S_MAR | S_Z, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, irv);
    for (int w = 0; w <= nWait; w++) begin
      mr = (w == nWait);
      cyc("T1", mk(5'd19, 16'd0, S_RD | ((w == 0) ? S_PC : 10'd0) | (mr ? S_MDR : 10'd0),
                   5'd0, 1'b1, 1'b0, 1'b0), 1'b0, mr, irv);
    end
    cyc("T2", mk(5'd21, 16'd0, S_IR, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, irv);
    if (!legal) begin
      cyc("T3-illegal", mk(5'd0, 16'd0, 10'd0, 5'd0, 1'b1, 1'b1, 1'b1), endStart, 1'b1, irv);
      return;
    end
    cyc("T3", mk({1'b0, rb}, 16'd0, S_Y, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, irv);
    cyc("T4", mk((op == 5'd12) ? 5'd23 : {1'b0, rc}, 16'd0, S_Z, op, 1'b1, 1'b0, 1'b0),
        1'b0, 1'b1, irv);
    if (mulDiv) begin
      cyc("T5-lo", mk(5'd19, 16'd0, S_LO, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, irv);
      cyc("T6-hi", mk(5'd18, 16'd0, S_HI, 5'd0, 1'b1, 1'b1, 1'b0), endStart, 1'b1, irv);
    end else begin
      cyc("T5-wb", mk(5'd19, 16'd1 << ra, 10'd0, 5'd0, 1'b1, 1'b1, 1'b0), endStart, 1'b1, irv);
    end
  endtask

  initial begin
    logic [31:0] irAdd, irMul, irDiv, irAddi, irIll, irSub0, irAnd, irOr;
    irAdd  = mkIr(5'b00011, 4'd3, 4'd1, 4'd2);
    irMul  = mkIr(5'b01111, 4'd0, 4'd4, 4'd5);
    irDiv  = mkIr(5'b10000, 4'd9, 4'd6, 4'd7);
    irAddi = mkIr(5'b01100, 4'd2, 4'd7, 4'd0);
    irIll  = mkIr(5'b11111, 4'd5, 4'd5, 4'd5);
    irSub0 = mkIr(5'b00100, 4'd0, 4'd14, 4'd15);
    irAnd  = mkIr(5'b00101, 4'd15, 4'd8, 4'd9);
    irOr   = mkIr(5'b00110, 4'd11, 4'd12, 4'd13);

    reset_n   = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b1;
    ir        = 32'd0;
    #2;
    push("reset-state", mk(5'd0, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    check();
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle(1'b0, 32'd0);
    idle(1'b0, 32'd0);

    // add, no memory wait
    idle(1'b1, irAdd);
    runInstr(irAdd, 0, 1'b0);
    idle(1'b0, irAdd);

    // add with three wait cycles in T1
    idle(1'b1, irAdd);
    runInstr(irAdd, 3, 1'b0);
    idle(1'b0, irAdd);

    // mul -> div -> addi back-to-back
    idle(1'b1, irMul);
    runInstr(irMul, 0, 1'b1);
    runInstr(irDiv, 1, 1'b1);
    runInstr(irAddi, 0, 1'b0);
    idle(1'b0, irAddi);

    // illegal with start held, then sub R0 / and / or back-to-back
    idle(1'b1, irIll);
    runInstr(irIll, 0, 1'b1);
    runInstr(irSub0, 0, 1'b1);
    runInstr(irAnd, 2, 1'b1);
    runInstr(irOr, 0, 1'b0);
    idle(1'b0, irOr);

    // asynchronous reset while sitting in T4 of an add
    idle(1'b1, irAdd);
    budget = 4;
    runInstr(irAdd, 0, 1'b0);
    budget = 1000000;
    @(posedge clock);
    #2;
    push("pre-reset-T4", mk(5'd2, 16'd0, S_Z, 5'b00011, 1'b1, 1'b0, 1'b0));
    check();
    reset_n = 1'b0;
    #1;
    push("async-reset", mk(5'd0, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    check();
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle(1'b0, irAdd);
    idle(1'b0, irAdd);
    idle(1'b0, irAdd);

    if (sb.size() != 0) begin
      tests++;
      failures++;
      $display("FAIL scoreboard-leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
